// File: rtl/wb_dma_raw_reader.sv
// wb_dma_raw_reader: reads 32-bit words from the raw port of the DMA buffer
// RAM and emits them as a little-endian byte stream (valid/ready).
// Optional checksum over the emitted bytes: define RAW_READER_CSUM_EN.
module wb_dma_raw_reader #(
    parameter int RAWP_ADDR_WIDTH = 9,
    parameter int LEN_WIDTH       = 11
) (
    input  logic                       rawp_clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [RAWP_ADDR_WIDTH-1:0] base_adr_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [RAWP_ADDR_WIDTH-1:0] rawp_adr_o,
    input  logic [31:0]                rawp_dat_i,
    output logic                       rawp_we_o,
    input  logic                       rawp_stall_i,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_valid_o,
    output logic                       tx_last_o,
    input  logic                       tx_ready_i
`ifdef RAW_READER_CSUM_EN
   ,output logic [15:0]                csum_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [RAWP_ADDR_WIDTH-1:0] r_adr;
    logic [LEN_WIDTH-1:0]       r_rem;
    logic [1:0]                 r_idx;
    logic [31:0]                r_word;
    logic                       w_start;
    logic                       w_capture;
    logic                       w_xfer;
    logic                       w_last_rem;
    logic [7:0]                 w_byte;

    assign w_last_rem = (r_rem == LEN_WIDTH'(1));
    assign w_byte     = r_word[{r_idx, 3'b000} +: 8];
    assign rawp_adr_o = r_adr;
    assign rawp_we_o  = 1'b0;
    assign tx_data_o  = w_byte;

    // State register
    always_ff @(posedge rawp_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state, handshake strobes and status outputs; abort beats a byte transfer
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_capture  = 1'b0;
        w_xfer     = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        tx_valid_o = 1'b0;
        tx_last_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_start = 1'b1;
                    w_next  = (len_i != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (!rawp_stall_i) begin
                    w_capture = 1'b1;
                    w_next    = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid_o = 1'b1;
                tx_last_o  = w_last_rem;
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (tx_ready_i) begin
                    w_xfer = 1'b1;
                    if (w_last_rem)          w_next = S_DONE;
                    else if (r_idx == 2'd3)  w_next = S_FETCH;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word address, remaining byte count, byte index and fetched word
    always_ff @(posedge rawp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr  <= '0;
            r_rem  <= '0;
            r_idx  <= '0;
            r_word <= '0;
        end else begin
            if (w_start && len_i != '0) begin
                r_adr <= base_adr_i;
                r_rem <= len_i;
            end
            if (w_capture) begin
                r_word <= rawp_dat_i;
                r_idx  <= '0;
            end
            if (w_xfer) begin
                r_rem <= r_rem - LEN_WIDTH'(1);
                r_idx <= r_idx + 2'd1;
                // Advance only when more bytes follow, so the address of the
                // final word stays visible after completion.
                if (r_idx == 2'd3 && !w_last_rem)
                    r_adr <= r_adr + RAWP_ADDR_WIDTH'(1);
            end
        end
    end

`ifdef RAW_READER_CSUM_EN
    logic [15:0] r_sum;
    logic [15:0] r_csum;
    logic [15:0] w_addend;
    logic [16:0] w_acc;
    logic [15:0] w_sum_nxt;

    // Even stream positions are the high byte of a pair; the word always
    // starts at an even position, so the index LSB gives the pairing.
    always_comb begin
        w_addend  = r_idx[0] ? {8'h00, w_byte} : {w_byte, 8'h00};
        w_acc     = {1'b0, r_sum} + {1'b0, w_addend};
        w_sum_nxt = w_acc[15:0] + {15'd0, w_acc[16]};
    end

    // Ones'-complement accumulator; result published as DONE is entered
    always_ff @(posedge rawp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_csum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
            if (len_i == '0) r_csum <= 16'hFFFF;
        end else if (w_xfer) begin
            r_sum <= w_sum_nxt;
            if (w_last_rem) r_csum <= ~w_sum_nxt;
        end
    end

    assign csum_o = r_csum;
`endif

endmodule

// File: tb/tb_wb_dma_raw_reader.sv
// Directed bench for wb_dma_raw_reader with a small raw-port RAM model.
module tb_wb_dma_raw_reader;

    logic        rawp_clk;
    logic        rst_n;
    logic        start_i;
    logic [8:0]  base_adr_i;
    logic [10:0] len_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  rawp_adr_o;
    logic [31:0] rawp_dat_i;
    logic        rawp_we_o;
    logic        rawp_stall_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_last_o;
    logic        tx_ready_i;
`ifdef RAW_READER_CSUM_EN
    logic [15:0] csum_o;
`endif

    wb_dma_raw_reader dut (
        .rawp_clk    (rawp_clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_adr_i  (base_adr_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rawp_adr_o  (rawp_adr_o),
        .rawp_dat_i  (rawp_dat_i),
        .rawp_we_o   (rawp_we_o),
        .rawp_stall_i(rawp_stall_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_last_o   (tx_last_o),
        .tx_ready_i  (tx_ready_i)
`ifdef RAW_READER_CSUM_EN
       ,.csum_o      (csum_o)
`endif
    );

    initial rawp_clk = 1'b0;
    always #5 rawp_clk = ~rawp_clk;

    // RAM model: word n holds bytes 4n..4n+3, byte 4n in the low lane.
    // While stalled the port returns junk so a premature capture shows up.
    function automatic logic [31:0] mem_word(input logic [8:0] a);
        logic [7:0] b;
        b = 8'({a, 2'b00});
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction
    assign rawp_dat_i = rawp_stall_i ? 32'hDEAD_BEEF : mem_word(rawp_adr_o);

    int n_cmp = 0;
    int n_err = 0;

    // Observations gathered by run_xfer
    logic [7:0]  got[$];
    bit          lastf[$];
    logic [8:0]  adrs[$];
    logic [8:0]  stall_adrs[$];
    int          busy_cnt, done_cnt, done_cyc, first_valid, last_cyc, stab_err;
    bit          timeout;
    logic [15:0] csum_at_done;

    // Issue one command and watch it until the engine returns to idle.
    // bp=1: ready toggles every cycle and the second fetch stalls 3 cycles.
    task automatic run_xfer(input logic [8:0] base, input logic [10:0] len,
                            input bit bp, input int abort_after);
        int   stall_left, fetch_ep;
        bit   prev_fetch, prev_valid, prev_ready, is_fetch;
        logic [7:0] prev_data;
        got.delete(); lastf.delete(); adrs.delete(); stall_adrs.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
        last_cyc = -1; stab_err = 0; timeout = 1'b1; csum_at_done = 16'h0;
        stall_left = 3; fetch_ep = 0;
        prev_fetch = 0; prev_valid = 0; prev_ready = 0; prev_data = 8'h0;
        @(posedge rawp_clk); #1;
        start_i = 1'b1; base_adr_i = base; len_i = len; tx_ready_i = 1'b1;
        @(posedge rawp_clk); #1;
        start_i = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!busy_o) begin timeout = 1'b0; break; end
            busy_cnt++;
            if (done_o) begin
                done_cnt++; done_cyc = cyc;
`ifdef RAW_READER_CSUM_EN
                csum_at_done = csum_o;
`endif
            end
            is_fetch = busy_o && !tx_valid_o && !done_o;
            if (is_fetch && !prev_fetch) fetch_ep++;
            if (bp && is_fetch && fetch_ep == 2 && stall_left > 0) begin
                rawp_stall_i = 1'b1; stall_left--;
                stall_adrs.push_back(rawp_adr_o);
            end else begin
                rawp_stall_i = 1'b0;
            end
            if (is_fetch && !rawp_stall_i) adrs.push_back(rawp_adr_o);
            tx_ready_i = bp ? (cyc % 2 == 0) : 1'b1;
            abort_i = (abort_after >= 0 && got.size() == abort_after && tx_valid_o);
            if (tx_valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_valid && !prev_ready && tx_data_o !== prev_data) stab_err++;
                if (tx_ready_i && !abort_i) begin
                    got.push_back(tx_data_o);
                    lastf.push_back(tx_last_o);
                    if (tx_last_o) last_cyc = cyc;
                end
            end
            prev_fetch = is_fetch; prev_valid = tx_valid_o;
            prev_ready = tx_ready_i; prev_data = tx_data_o;
            @(posedge rawp_clk); #1;
        end
        abort_i = 1'b0; rawp_stall_i = 1'b0; tx_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_i = 1'b0; base_adr_i = '0; len_i = '0;
        abort_i = 1'b0; rawp_stall_i = 1'b0; tx_ready_i = 1'b1;
        #12;
        n_cmp++;
        if ({busy_o, done_o, tx_valid_o, tx_last_o, rawp_we_o} !== 5'b0 ||
            tx_data_o !== 8'h0 || rawp_adr_o !== 9'h0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b valid=%b last=%b we=%b data=%h adr=%h, want all 0",
                     busy_o, done_o, tx_valid_o, tx_last_o, rawp_we_o, tx_data_o, rawp_adr_o);
        end
`ifdef RAW_READER_CSUM_EN
        n_cmp++;
        if (csum_o !== 16'h0) begin
            n_err++; $display("FAIL reset_csum: got %h want 0000", csum_o);
        end
`endif
        @(negedge rawp_clk); rst_n = 1'b1;
        repeat (2) @(posedge rawp_clk);
    endtask

    task automatic test_basic;
        logic [7:0] exp[$];
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_xfer(9'd0, 11'd8, 1'b0, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL basic_timeout: no idle within budget"); end
        n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL basic_count: got %0d bytes want 8", got.size()); end
        foreach (exp[i]) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        for (int i = 0; i < lastf.size(); i++) begin
            n_cmp++;
            if (lastf[i] !== (i == 7)) begin
                n_err++; $display("FAIL basic_last%0d: got %b want %b", i, lastf[i], (i == 7));
            end
        end
        n_cmp++; if (first_valid != 1) begin n_err++; $display("FAIL basic_first_valid: cycle %0d want 1", first_valid); end
        n_cmp++; if (busy_cnt != 11) begin n_err++; $display("FAIL basic_busy: %0d cycles want 11", busy_cnt); end
        n_cmp++; if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
            n_err++; $display("FAIL basic_done: count %0d at %0d, last byte at %0d want 1 pulse next cycle", done_cnt, done_cyc, last_cyc);
        end
        n_cmp++; if (adrs.size() != 2 || adrs[0] !== 9'd0 || adrs[1] !== 9'd1) begin
            n_err++; $display("FAIL basic_adrs: got %p want 0,1", adrs);
        end
    endtask

    task automatic test_partial;
        logic [7:0] exp[$];
        exp = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        run_xfer(9'd5, 11'd6, 1'b0, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL partial_timeout: no idle within budget"); end
        n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL partial_count: got %0d bytes want 6", got.size()); end
        foreach (exp[i]) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL partial_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++; if (adrs.size() != 2 || adrs[0] !== 9'd5 || adrs[1] !== 9'd6) begin
            n_err++; $display("FAIL partial_adrs: got %p want 5,6", adrs);
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL partial_done: %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp[$];
        exp = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        run_xfer(9'd511, 11'd8, 1'b0, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL wrap_timeout: no idle within budget"); end
        n_cmp++; if (adrs.size() != 2 || adrs[0] !== 9'd511 || adrs[1] !== 9'd0) begin
            n_err++; $display("FAIL wrap_adrs: got %p want 511,0", adrs);
        end
        n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL wrap_count: got %0d bytes want 8", got.size()); end
        foreach (exp[i]) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp[$];
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_xfer(9'd0, 11'd8, 1'b1, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL bp_timeout: no idle within budget"); end
        n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL bp_count: got %0d bytes want 8", got.size()); end
        foreach (exp[i]) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL bp_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL bp_stable: %0d data changes while stalled want 0", stab_err); end
        n_cmp++; if (stall_adrs.size() != 3) begin n_err++; $display("FAIL bp_stall_len: %0d stalled fetch cycles want 3", stall_adrs.size()); end
        foreach (stall_adrs[i]) begin
            n_cmp++;
            if (stall_adrs[i] !== 9'd1) begin n_err++; $display("FAIL bp_stall_adr%0d: got %0d want 1", i, stall_adrs[i]); end
        end
        n_cmp++; if (adrs.size() != 2 || adrs[0] !== 9'd0 || adrs[1] !== 9'd1) begin
            n_err++; $display("FAIL bp_adrs: got %p want 0,1", adrs);
        end
    endtask

    task automatic test_zero_len;
        run_xfer(9'd3, 11'd0, 1'b0, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL zero_timeout: no idle within budget"); end
        n_cmp++; if (done_cyc != 0 || done_cnt != 1) begin
            n_err++; $display("FAIL zero_done: pulse at cycle %0d count %0d want cycle 0 count 1", done_cyc, done_cnt);
        end
        n_cmp++; if (first_valid != -1 || got.size() != 0) begin
            n_err++; $display("FAIL zero_valid: valid seen at %0d, %0d bytes want none", first_valid, got.size());
        end
        n_cmp++; if (busy_cnt != 1) begin n_err++; $display("FAIL zero_busy: %0d cycles want 1", busy_cnt); end
`ifdef RAW_READER_CSUM_EN
        n_cmp++; if (csum_at_done !== 16'hFFFF) begin n_err++; $display("FAIL zero_csum: got %h want ffff", csum_at_done); end
`endif
    endtask

    task automatic test_abort;
        run_xfer(9'd0, 11'd8, 1'b0, 2);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL abort_timeout: no idle within budget"); end
        n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL abort_count: got %0d bytes want 2", got.size()); end
        n_cmp++; if (busy_cnt != 4) begin n_err++; $display("FAIL abort_busy: %0d cycles want 4", busy_cnt); end
        n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", tx_valid_o); end
        @(posedge rawp_clk); #1;
        n_cmp++; if (done_cnt != 0 || done_o !== 1'b0) begin
            n_err++; $display("FAIL abort_done: %0d pulses, done_o=%b want none", done_cnt, done_o);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge rawp_clk); #1;
        start_i = 1'b1; base_adr_i = 9'd2; len_i = 11'd8; tx_ready_i = 1'b1;
        @(posedge rawp_clk); #1;
        start_i = 1'b0;
        @(posedge rawp_clk); #1;
        @(posedge rawp_clk); #1;
        n_cmp++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h09) begin
            n_err++; $display("FAIL rst_mid_pre: valid=%b data=%h want 1 and 09", tx_valid_o, tx_data_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, tx_valid_o, tx_last_o} !== 4'b0 ||
            tx_data_o !== 8'h0 || rawp_adr_o !== 9'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b valid=%b last=%b data=%h adr=%h, want all 0",
                     busy_o, done_o, tx_valid_o, tx_last_o, tx_data_o, rawp_adr_o);
        end
        @(negedge rawp_clk); rst_n = 1'b1;
        repeat (2) @(posedge rawp_clk);
        #1;
        n_cmp++; if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after: busy=%b valid=%b want 0 0", busy_o, tx_valid_o);
        end
    endtask

`ifdef RAW_READER_CSUM_EN
    task automatic test_csum;
        run_xfer(9'd0, 11'd5, 1'b0, -1);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL csum_timeout: no idle within budget"); end
        n_cmp++; if (csum_at_done !== 16'hF9FB) begin n_err++; $display("FAIL csum_done: got %h want f9fb", csum_at_done); end
        n_cmp++; if (csum_o !== 16'hF9FB) begin n_err++; $display("FAIL csum_hold: got %h want f9fb", csum_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_abort();
`ifdef RAW_READER_CSUM_EN
        test_csum();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
